p2s_idle_tx: RTL and testbench
==============================

# p2s_idle_tx

Parallel-to-serial transmitter with idle (comma) insertion. It is the transmit end of the serial link whose receiver searches for repeated 8'hBC commas before it declares the link active and drops its IDLE indication. The block accepts bytes through a one-entry valid/ready buffer and serializes them MSB first on a single bit line at clk_32f. On reset it first sends SYNC_COUNT commas. After that, any byte slot with no buffered data carries a comma.

## Interface
- COMMA, 8'hBC: idle/sync character sent when no data is available.
- SYNC_COUNT, 4: number of commas sent after reset before data is accepted (range 1..15).
- clk_32f  input  1  bit clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  parallel byte to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  buffer can accept a byte; combinational, equals (state==ACTIVE) && !buf_full.
- data_out  output  1  registered serial bit, MSB of each byte first.
- idle_out  output  1  registered; 1 while the current slot carries an inserted comma.
- sync_done  output  1  registered; 1 once the SYNC_COUNT commas have been committed.

## Operation
- Internal state:
  - bit counter cnt[2:0], the index of the bit currently on data_out (0 = MSB).
  - shift/hold register sh[7:0].
  - buffer buf[7:0] with flag buf_full.
  - sync counter sync_cnt[3:0].
  - state, either SYNC or ACTIVE.
- Reset values:
  - Outputs: data_out=0, idle_out=0, sync_done=0, ready_out=0.
  - Internal: cnt=7, sh=0, buf_full=0, sync_cnt=0, state=SYNC.
- Each rising edge advances cnt by 1, wrapping from 7 to 0.
- Load edge (cnt currently 7):
  - Select next byte: buf if state==ACTIVE and buf_full (then clear buf_full, idle_out<=0); otherwise COMMA (idle_out<=1).
  - sh<=next, data_out<=next[7].
- Other edges: data_out<=sh[6-cnt], giving bits 6..0 in order.
- SYNC state:
  - Every load edge sends COMMA and increments sync_cnt.
  - On the load edge where sync_cnt==SYNC_COUNT-1: state<=ACTIVE, sync_done<=1.
  - ready_out stays 0 throughout SYNC.
- ACTIVE state:
  - Accept on an edge with valid_in && ready_out: buf<=data_in, buf_full<=1.
  - The buffer is one entry, and ready_out is 0 while it is full, so accept and load never collide on a full buffer.
  - Accept on a load edge with an empty buffer: the current slot gets COMMA; the accepted byte goes out in the next slot.
- Data equal to COMMA is transmitted with idle_out=0. Only inserted commas assert idle_out.
- Reset asserted mid-byte: all state returns to reset values immediately. The partially sent byte is truncated, any buffered byte is discarded, and SYNC restarts.

## Timing
- Edges are numbered from the first rising edge after reset deasserts (edge 1).
- Slot k (k≥1) occupies edges 8k-7 .. 8k. Its bit 7 appears on data_out after edge 8k-7.
- Sync commas: edges 1, 9, 17, 25 load commas 1 through 4 (SYNC_COUNT=4).
  - Edge 25 sets state=ACTIVE and sync_done=1.
  - ready_out rises in the cycle after edge 25.
- Latency, accept to first bit on line: 1 to 8 edges. The byte starts at the next load edge strictly after the accept.
- Throughput: one byte per 8 clocks. With valid_in held high and a fresh byte after each accept, there are no commas between bytes.
- ready_out falls in the cycle after an accept and rises in the cycle after the load that empties the buffer.
- idle_out and data_out change on the same edge at slot boundaries.

## Test plan
- Reset, then hold valid_in=0 for 48 edges:
  - data_out shows six repetitions of 1,0,1,1,1,1,0,0 starting after edge 1, with idle_out=1 throughout.
  - sync_done rises at edge 25.
  - ready_out stays 0 until after edge 25.
- After sync, present 8'hA5 with valid_in on edge 26 → slot 5 (edges 33..40) carries 1,0,1,0,0,1,0,1 with idle_out=0; slot 6 is a comma with idle_out=1.
- Back-to-back 8'hFF, 8'h00, 8'h3C, each presented as soon as ready_out is high → three contiguous slots 11111111, 00000000, 00111100; idle_out=0 across all three; no comma between them.
- Send 8'hBC as data → serial pattern identical to a comma, but idle_out=0 for that slot.
- Accept 8'h81, then assert reset at edge 36 (mid-slot 5), deassert at edge 38:
  - data_out, idle_out, sync_done, ready_out all go 0 immediately.
  - 8'h81 is never sent.
  - Four sync commas follow before ready_out rises again.
- valid_in held while buf_full → the byte is not accepted until ready_out rises; the byte sequence is verified exact, with no loss and no duplication.

Source files
------------

// File: rtl/p2s_idle_tx.sv
// rtl/p2s_idle_tx.sv - parallel-to-serial transmitter with comma insertion
module p2s_idle_tx #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       idle_out,
    output logic       sync_done
);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic [7:0] sh;
    logic [7:0] buf_q;
    logic       buf_full;
    logic [3:0] sync_cnt, sync_cnt_nxt;
    logic       sync_done_nxt;
    logic       load;
    logic       take_buf;
    logic [7:0] next_byte;
    logic       accept;

    assign ready_out = (state == ACTIVE) && !buf_full;
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_nxt     = state;
        sync_cnt_nxt  = sync_cnt;
        sync_done_nxt = sync_done;
        load          = (cnt == 3'd7);
        take_buf      = load && (state == ACTIVE) && buf_full;
        next_byte     = take_buf ? buf_q : COMMA;
        if (load && (state == SYNC)) begin
            sync_cnt_nxt = sync_cnt + 4'd1;
            if (sync_cnt == 4'(SYNC_COUNT - 1)) begin
                state_nxt     = ACTIVE;
                sync_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            sync_cnt  <= 4'd0;
            sync_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync_cnt  <= sync_cnt_nxt;
            sync_done <= sync_done_nxt;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            cnt      <= 3'd7;
            sh       <= 8'd0;
            buf_q    <= 8'd0;
            buf_full <= 1'b0;
            data_out <= 1'b0;
            idle_out <= 1'b0;
        end else begin
            cnt <= cnt + 3'd1;
            if (load) begin
                sh       <= next_byte;
                data_out <= next_byte[7];
                idle_out <= !take_buf;
                if (take_buf)
                    buf_full <= 1'b0;
            end else begin
                data_out <= sh[3'd6 - cnt];
            end
            // ready_out is low while full, so an accept never overlaps take_buf
            if (accept) begin
                buf_q    <= data_in;
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p2s_idle_tx.sv
// tb/tb_p2s_idle_tx.sv - directed self-checking bench for p2s_idle_tx
module tb_p2s_idle_tx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       ready_out, data_out, idle_out, sync_done;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    logic [7:0] rx_byte[$];
    logic       rx_idle[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_acc = 8'd0;
    logic       mon_idle = 1'b0;

    p2s_idle_tx dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .idle_out (idle_out),
        .sync_done(sync_done)
    );

    always #5 clk_32f = ~clk_32f;

    always @(posedge clk_32f or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Reassemble slots: slot k spans edges 8k-7..8k, sampled mid-cycle
    always @(negedge clk_32f) begin
        if (!reset && edge_n >= 1) begin
            automatic logic [7:0] b = {mon_acc[6:0], data_out};
            mon_acc <= b;
            if ((edge_n - 1) % 8 == 0) mon_idle <= idle_out;
            if ((edge_n - 1) % 8 == 7) begin
                rx_byte.push_back(b);
                rx_idle.push_back(mon_idle);
            end
        end
    end

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic wait_edge(input int n);
        for (int g = 0; g < 1000 && edge_n < n; g++) tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rx_byte.delete();
        rx_idle.delete();
    endtask

    task automatic feed();
        for (int g = 0; g < 200 && tx_q.size() > 0; g++) begin
            logic acc;
            valid_in = ready_out;
            data_in  = tx_q[0];
            acc = valid_in && ready_out;
            tick();
            if (acc) void'(tx_q.pop_front());
        end
        valid_in = 1'b0;
    endtask

    task automatic collect(input int n, output int first);
        first = -1;
        for (int g = 0; g < 300; g++) begin
            int f = -1;
            for (int i = 0; i < rx_idle.size(); i++)
                if (f < 0 && rx_idle[i] == 1'b0) f = i;
            if (f >= 0 && rx_byte.size() >= f + n + 1) begin
                first = f;
                break;
            end
            tick();
        end
    endtask

    task automatic check_seq(input string name);
        int f;
        collect(exp_q.size(), f);
        n_cmp++;
        if (f < 0) begin
            n_err++;
            $display("FAIL %s: timeout, got %0d slots, required %0d data slots", name, rx_byte.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (rx_byte[f+i] !== exp_q[i] || rx_idle[f+i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s[%0d]: got %h idle=%b, required %h idle=0", name, i, rx_byte[f+i], rx_idle[f+i], exp_q[i]);
                end
            end
            n_cmp++;
            if (rx_byte[f+exp_q.size()] !== 8'hBC || rx_idle[f+exp_q.size()] !== 1'b1) begin
                n_err++;
                $display("FAIL %s_tail: got %h idle=%b, required bc idle=1", name, rx_byte[f+exp_q.size()], rx_idle[f+exp_q.size()]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({data_out, idle_out, sync_done, ready_out} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 0000", {data_out, idle_out, sync_done, ready_out});
        end
        tick();
        reset = 1'b0;
        rx_byte.delete();
        rx_idle.delete();
        for (int e = 1; e <= 48; e++) begin
            tick();
            n_cmp++;
            if (sync_done !== (e >= 25) || ready_out !== (e >= 25)) begin
                n_err++;
                $display("FAIL sync_timing@%0d: sync_done=%b ready_out=%b, required %b", e, sync_done, ready_out, e >= 25);
            end
        end
        tick();
        n_cmp++;
        if (rx_byte.size() < 6) begin
            n_err++;
            $display("FAIL sync_slots: got %0d slots, required 6", rx_byte.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (rx_byte[i] !== 8'hBC || rx_idle[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL sync_comma[%0d]: got %h idle=%b, required bc idle=1", i, rx_byte[i], rx_idle[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        wait_edge(25);
        data_in  = 8'hA5;
        valid_in = 1'b1;
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_sync: got %b, required 1", ready_out);
        end
        tick();
        valid_in = 1'b0;
        wait_edge(32);
        n_cmp++;
        if (ready_out !== 1'b0) begin
            n_err++;
            $display("FAIL ready_while_full: got %b, required 0", ready_out);
        end
        tick();
        n_cmp++;
        if ({ready_out, data_out, idle_out} !== 3'b110) begin
            n_err++;
            $display("FAIL load_edge33: got ready/data/idle %b, required 110", {ready_out, data_out, idle_out});
        end
        wait_edge(49);
        n_cmp++;
        if (rx_byte.size() < 6) begin
            n_err++;
            $display("FAIL single_slots: got %0d slots, required 6", rx_byte.size());
        end else begin
            n_cmp++;
            if (rx_byte[4] !== 8'hA5 || rx_idle[4] !== 1'b0) begin
                n_err++;
                $display("FAIL single_slot5: got %h idle=%b, required a5 idle=0", rx_byte[4], rx_idle[4]);
            end
            n_cmp++;
            if (rx_byte[5] !== 8'hBC || rx_idle[5] !== 1'b1) begin
                n_err++;
                $display("FAIL single_slot6: got %h idle=%b, required bc idle=1", rx_byte[5], rx_idle[5]);
            end
        end
    endtask

    task automatic test_back_to_back();
        rx_byte.delete();
        rx_idle.delete();
        tx_q  = '{8'hFF, 8'h00, 8'h3C};
        exp_q = tx_q;
        feed();
        check_seq("b2b");
    endtask

    task automatic test_comma_data();
        rx_byte.delete();
        rx_idle.delete();
        tx_q  = '{8'hBC};
        exp_q = tx_q;
        feed();
        check_seq("comma_data");
    endtask

    task automatic test_stall();
        rx_byte.delete();
        rx_idle.delete();
        tx_q  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        exp_q = tx_q;
        for (int g = 0; g < 200 && tx_q.size() > 0; g++) begin
            logic acc;
            valid_in = 1'b1;
            data_in  = tx_q[0];
            acc = ready_out;
            tick();
            if (acc) begin
                void'(tx_q.pop_front());
                n_cmp++;
                if (ready_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_ready_fall: got %b, required 0", ready_out);
                end
            end
        end
        valid_in = 1'b0;
        check_seq("stall");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        wait_edge(25);
        data_in  = 8'h81;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_edge(35);
        n_cmp++;
        if ({sync_done, ready_out} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset: got sync/ready %b, required 11", {sync_done, ready_out});
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({data_out, idle_out, sync_done, ready_out} !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b, required 0000", {data_out, idle_out, sync_done, ready_out});
        end
        tick();
        tick();
        reset = 1'b0;
        rx_byte.delete();
        rx_idle.delete();
        for (int e = 1; e <= 40; e++) begin
            tick();
            n_cmp++;
            if (ready_out !== (e >= 25)) begin
                n_err++;
                $display("FAIL resync_ready@%0d: got %b, required %b", e, ready_out, e >= 25);
            end
        end
        tick();
        n_cmp++;
        if (rx_byte.size() < 5) begin
            n_err++;
            $display("FAIL resync_slots: got %0d slots, required 5", rx_byte.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (rx_byte[i] !== 8'hBC || rx_idle[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL resync_comma[%0d]: got %h idle=%b, required bc idle=1", i, rx_byte[i], rx_idle[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_comma_data();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
